fir_seq_ctrl: RTL and testbench

FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

---
 rtl/fir_seq_ctrl.sv | 156 +++++++++++++++
 tb/tb_fir_seq_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_seq_ctrl.sv
// Sequences one FIR output per accepted sample through shared data/tap BRAMs; sm_tvalid rises T+3 cycles after the input accept.
// Backpressure: sm_tvalid holds until sm_tready, and ss_tready stays low from accept until the output handshake.
module fir_seq_ctrl #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   ap_start,
    input  logic [31:0]            data_length,
    input  logic                   ss_tvalid,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    output logic                   ss_tready,
    input  logic                   sm_tready,
    output logic                   sm_tvalid,
    output logic                   sm_tlast,
    output logic [3:0]             data_WE,
    output logic [pADDR_WIDTH-1:0] data_A,
    output logic [pADDR_WIDTH-1:0] tap_A,
    output logic [pDATA_WIDTH-1:0] data_Di,
    output logic                   Data_control,
    output logic                   Tape_control,
    output logic                   adder_rst_control,
    output logic                   output_control,
    output logic                   cal_rst_n,
    output logic                   ap_idle,
    output logic                   ap_done,
    output logic                   err_tlast
);
    localparam int WW = (Tape_Num > 1) ? $clog2(Tape_Num) : 1;
    localparam int CW = $clog2(Tape_Num + 4);
    localparam logic [CW-1:0] T_K    = CW'(Tape_Num);
    localparam logic [CW-1:0] LAST_K = CW'(Tape_Num + 3);
    localparam logic [CW-1:0] ACC_K  = CW'(3);
    localparam logic [WW-1:0] WP_MAX = WW'(Tape_Num - 1);

    typedef enum logic [2:0] {IDLE, WAIT_IN, CALC, OUT, DONE} state_t;

    state_t                 state;
    logic [WW-1:0]          wp;
    logic [31:0]            n;
    logic [31:0]            len;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          k;
    logic [15:0]            rd_sum;
    logic [WW-1:0]          rd_idx;
    logic [pADDR_WIDTH-1:0] rd_addr_q;
    logic                   accept;

    assign accept  = ss_tvalid && ss_tready;
    assign k       = cnt + CW'(1);
    assign data_WE = accept ? 4'hF : 4'h0;
    assign data_Di = ss_tdata;
    assign data_A  = ss_tready ? pADDR_WIDTH'({wp, 2'b00}) : rd_addr_q;

    // Ring slot holding sample n-k; only consulted while k < T.
    always_comb begin
        rd_sum = 16'(wp) + 16'(Tape_Num) - 16'(k);
        rd_idx = (rd_sum >= 16'(Tape_Num)) ? WW'(rd_sum - 16'(Tape_Num)) : WW'(rd_sum);
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state             <= IDLE;
            wp                <= '0;
            n                 <= '0;
            len               <= '0;
            cnt               <= '0;
            err_tlast         <= 1'b0;
            ss_tready         <= 1'b0;
            sm_tvalid         <= 1'b0;
            sm_tlast          <= 1'b0;
            tap_A             <= '0;
            rd_addr_q         <= '0;
            Data_control      <= 1'b1;
            Tape_control      <= 1'b1;
            adder_rst_control <= 1'b1;
            output_control    <= 1'b0;
            cal_rst_n         <= 1'b0;
            ap_done           <= 1'b0;
            ap_idle           <= 1'b1;
        end else begin
            cal_rst_n <= 1'b1;
            ap_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        len     <= data_length;
                        ap_idle <= 1'b0;
                        if (data_length == 32'd0) begin
                            state   <= DONE;
                            ap_done <= 1'b1;
                        end else begin
                            state     <= WAIT_IN;
                            ss_tready <= 1'b1;
                            wp        <= '0;
                            n         <= '0;
                            err_tlast <= 1'b0;
                            cal_rst_n <= 1'b0;
                        end
                    end
                end
                WAIT_IN: begin
                    if (accept) begin
                        state     <= CALC;
                        ss_tready <= 1'b0;
                        cnt       <= '0;
                        tap_A     <= '0;
                        rd_addr_q <= pADDR_WIDTH'({wp, 2'b00});
                        if (ss_tlast != (n == len - 32'd1))
                            err_tlast <= 1'b1;
                    end
                end
                CALC: begin
                    // Registered values below are those of cycle k after the accept.
                    cnt               <= k;
                    tap_A             <= (k < T_K) ? pADDR_WIDTH'({k, 2'b00}) : '0;
                    rd_addr_q         <= (k < T_K) ? pADDR_WIDTH'({rd_idx, 2'b00}) : '0;
                    Tape_control      <= !(k <= T_K);
                    Data_control      <= !((k <= T_K) && (32'(cnt) <= n));
                    adder_rst_control <= (k < ACC_K);
                    if (k == LAST_K) begin
                        state          <= OUT;
                        output_control <= 1'b1;
                        sm_tvalid      <= 1'b1;
                        sm_tlast       <= (n == len - 32'd1);
                    end
                end
                OUT: begin
                    output_control    <= 1'b0;
                    adder_rst_control <= 1'b1;
                    if (sm_tready) begin
                        sm_tvalid <= 1'b0;
                        sm_tlast  <= 1'b0;
                        wp        <= (wp == WP_MAX) ? '0 : wp + WW'(1);
                        n         <= n + 32'd1;
                        if (n + 32'd1 == len) begin
                            state   <= DONE;
                            ap_done <= 1'b1;
                        end else begin
                            state     <= WAIT_IN;
                            ss_tready <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    ap_idle <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Bench for fir_seq_ctrl: behavioural BRAMs plus MAC stage, FIR reference model and a queue scoreboard.
`timescale 1ns/1ps
module tb_fir_seq_ctrl;
    localparam int T   = 11;
    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int LAT = T + 3;

    logic          axis_clk = 1'b0;
    logic          axis_rst = 1'b1;
    logic          ap_start = 1'b0;
    logic [31:0]   data_length = '0;
    logic          ss_tvalid = 1'b0;
    logic [DW-1:0] ss_tdata = '0;
    logic          ss_tlast = 1'b0;
    logic          ss_tready;
    logic          sm_tready = 1'b1;
    logic          sm_tvalid, sm_tlast;
    logic [DW-1:0] sm_tdata;
    logic [3:0]    data_WE;
    logic [AW-1:0] data_A, tap_A;
    logic [DW-1:0] data_Di;
    logic          Data_control, Tape_control, adder_rst_control, output_control;
    logic          cal_rst_n, ap_idle, ap_done, err_tlast;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rdy_pct = 100;
    bit hold = 1'b0;

    logic [DW-1:0] h [T];
    logic [DW-1:0] dmem [T];
    logic [DW-1:0] xh[$];
    logic [DW:0]   exp_q[$];
    int            ea_q[$];

    fir_seq_ctrl #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(T)) dut (
        .axis_clk(axis_clk), .axis_rst(axis_rst), .ap_start(ap_start), .data_length(data_length),
        .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
        .sm_tready(sm_tready), .sm_tvalid(sm_tvalid), .sm_tlast(sm_tlast),
        .data_WE(data_WE), .data_A(data_A), .tap_A(tap_A), .data_Di(data_Di),
        .Data_control(Data_control), .Tape_control(Tape_control),
        .adder_rst_control(adder_rst_control), .output_control(output_control),
        .cal_rst_n(cal_rst_n), .ap_idle(ap_idle), .ap_done(ap_done), .err_tlast(err_tlast)
    );

    always #5 axis_clk = ~axis_clk;
    always @(posedge axis_clk) cyc <= cyc + 1;

    // Attached calc stage: 1-cycle BRAM reads, masked operands, multiply, accumulate, output latch.
    logic [DW-1:0] dq = '0, tq = '0, a_r = '0, b_r = '0, prod_r = '0, acc = '0, y_hold = '0;
    always @(posedge axis_clk) begin
        if (data_WE == 4'hF && int'(data_A[AW-1:2]) < T) dmem[data_A[AW-1:2]] <= data_Di;
        dq <= (int'(data_A[AW-1:2]) < T) ? dmem[data_A[AW-1:2]] : '0;
        tq <= (int'(tap_A[AW-1:2]) < T) ? h[tap_A[AW-1:2]] : '0;
        if (!cal_rst_n) begin
            a_r <= '0; b_r <= '0; prod_r <= '0; acc <= '0; y_hold <= '0;
        end else begin
            a_r    <= Data_control ? '0 : dq;
            b_r    <= Tape_control ? '0 : tq;
            prod_r <= a_r * b_r;
            acc    <= adder_rst_control ? '0 : acc + prod_r;
            if (output_control) y_hold <= acc;
        end
    end
    assign sm_tdata = output_control ? acc : y_hold;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, 64'(act), 64'(exp));
    endtask

    task automatic fail(input string name, input string why);
        total++;
        bad++;
        $display("FAIL %s: %s (t=%0t)", name, why, $time);
    endtask

    // y[n] = sum over taps of h[t]*x[n-t], with samples before the first treated as zero.
    function automatic logic [DW-1:0] ref_y(input int nn);
        logic [DW-1:0] s = '0;
        for (int t = 0; t < T; t++)
            if (nn - t >= 0) s += h[t] * xh[nn - t];
        return s;
    endfunction

    task automatic tick();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic start(input logic [31:0] nlen);
        tick();
        data_length = nlen;
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
    endtask

    task automatic send_sample(input logic [DW-1:0] x, input logic last, input int nn, input int nlen);
        int b = 0;
        ss_tvalid = 1'b1;
        ss_tdata  = x;
        ss_tlast  = last;
        @(negedge axis_clk);
        while (!ss_tready && b < 400) begin
            @(negedge axis_clk);
            b++;
        end
        if (!ss_tready) begin
            fail("accept_timeout", "ss_tready never rose");
            ss_tvalid = 1'b0;
            tick();
            return;
        end
        check("acc_we", 64'(data_WE), 64'(4'hF));
        check("acc_addr", 64'(data_A), 64'(4 * (nn % T)));
        check("acc_di", 64'(data_Di), 64'(x));
        ea_q.push_back(cyc + 1);
        xh.push_back(x);
        exp_q.push_back({(nn == nlen - 1), ref_y(nn)});
        tick();
        ss_tvalid = 1'b0;
        ss_tlast  = 1'b0;
    endtask

    // ramp: x = n+1, otherwise random samples; early >= 0 moves ss_tlast to that index.
    task automatic run_job(input int nlen, input int early, input int gap_max, input bit ramp, input bit poke);
        int b = 0;
        logic exp_err = 1'b0;
        logic lst;
        logic [DW-1:0] x;
        xh.delete();
        start(32'(nlen));
        @(negedge axis_clk);
        check1("run_idle", ap_idle, 1'b0);
        check1("run_calrst", cal_rst_n, 1'b0);
        check1("run_ssrdy", ss_tready, 1'b1);
        tick();
        for (int i = 0; i < nlen; i++) begin
            repeat ($urandom_range(0, gap_max)) tick();
            lst = (early >= 0) ? (i == early) : (i == nlen - 1);
            exp_err |= (lst != (i == nlen - 1));
            x = ramp ? DW'(i + 1) : DW'($urandom);
            send_sample(x, lst, i, nlen);
            if (poke && i == 0) begin
                tick();
                data_length = '0;
                ap_start = 1'b1;
                tick();
                ap_start = 1'b0;
                data_length = 32'(nlen);
            end
        end
        do begin
            @(negedge axis_clk);
            b++;
        end while (!ap_done && b < 3000);
        if (!ap_done) begin
            fail("done_timeout", "ap_done never pulsed");
        end else begin
            check("drained", 64'(exp_q.size()), 64'(0));
            check1("err_tlast", err_tlast, exp_err);
            @(negedge axis_clk);
            check1("done_pulse", ap_done, 1'b0);
            check1("idle_after", ap_idle, 1'b1);
        end
        tick();
    endtask

    initial forever begin
        @(posedge axis_clk);
        #1;
        sm_tready = hold ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
    end

    initial begin : monitor
        logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
        logic [DW-1:0] pd = '0;
        logic [DW:0] e;
        forever begin
            @(negedge axis_clk);
            if (axis_rst) begin
                pv = 1'b0;
                continue;
            end
            if (!(ss_tvalid && ss_tready)) check("we_idle", 64'(data_WE), 64'(0));
            if (pv && !pr) begin
                check1("hold_vld", sm_tvalid, 1'b1);
                check("hold_dat", 64'(sm_tdata), 64'(pd));
                check1("hold_last", sm_tlast, pl);
                check1("hold_ssrdy", ss_tready, 1'b0);
            end else if (sm_tvalid) begin
                if (ea_q.size() == 0) fail("latency", "output with no accepted input");
                else check("latency", 64'(cyc - ea_q.pop_front()), 64'(LAT));
                check1("outctl", output_control, 1'b1);
            end
            if (sm_tvalid && sm_tready) begin
                if (exp_q.size() == 0) begin
                    fail("y", "output with empty scoreboard");
                end else begin
                    e = exp_q.pop_front();
                    check("y", 64'(sm_tdata), 64'(e[DW-1:0]));
                    check1("tlast", sm_tlast, e[DW]);
                end
            end
            pv = sm_tvalid;
            pr = sm_tready;
            pd = sm_tdata;
            pl = sm_tlast;
        end
    end

    initial begin : watchdog
        #900_000;
        bad++;
        $display("FAIL watchdog: time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int quiet;
        for (int i = 0; i < T; i++) dmem[i] = '0;
        repeat (3) @(posedge axis_clk);
        @(negedge axis_clk);
        check1("rst_ssrdy", ss_tready, 1'b0);
        check1("rst_smvld", sm_tvalid, 1'b0);
        check1("rst_smlast", sm_tlast, 1'b0);
        check("rst_we", 64'(data_WE), 64'(0));
        check("rst_data_a", 64'(data_A), 64'(0));
        check("rst_tap_a", 64'(tap_A), 64'(0));
        check1("rst_dctl", Data_control, 1'b1);
        check1("rst_tctl", Tape_control, 1'b1);
        check1("rst_addrst", adder_rst_control, 1'b1);
        check1("rst_outctl", output_control, 1'b0);
        check1("rst_calrst", cal_rst_n, 1'b0);
        check1("rst_done", ap_done, 1'b0);
        check1("rst_idle", ap_idle, 1'b1);
        check1("rst_err", err_tlast, 1'b0);
        tick();
        axis_rst = 1'b0;
        repeat (2) tick();

        // single impulse, taps 1..11
        for (int t = 0; t < T; t++) h[t] = DW'(t + 1);
        run_job(1, -1, 0, 1'b1, 1'b0);

        // ramp with ring wrap, all taps 1, a stray ap_start mid-run
        for (int t = 0; t < T; t++) h[t] = DW'(1);
        run_job(15, -1, 2, 1'b1, 1'b1);

        // N = 0
        tick();
        data_length = '0;
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        @(negedge axis_clk);
        check1("n0_done", ap_done, 1'b1);
        check1("n0_ssrdy", ss_tready, 1'b0);
        @(negedge axis_clk);
        check1("n0_done_fall", ap_done, 1'b0);
        check1("n0_idle", ap_idle, 1'b1);
        check1("n0_ssrdy2", ss_tready, 1'b0);
        tick();

        // 20-cycle output backpressure
        for (int t = 0; t < T; t++) h[t] = DW'($urandom_range(0, 1000));
        hold = 1'b1;
        fork
            run_job(3, -1, 1, 1'b0, 1'b0);
            begin
                int b = 0;
                while (!sm_tvalid && b < 500) begin
                    @(negedge axis_clk);
                    b++;
                end
                if (!sm_tvalid) fail("bp_wait", "sm_tvalid never rose");
                repeat (20) @(negedge axis_clk);
                check1("bp_still_vld", sm_tvalid, 1'b1);
                check1("bp_ssrdy", ss_tready, 1'b0);
                hold = 1'b0;
            end
        join

        // early ss_tlast on the second of four samples
        run_job(4, 1, 1, 1'b0, 1'b0);

        // reset during CALC
        xh.delete();
        start(32'd3);
        send_sample(DW'($urandom), 1'b0, 0, 3);
        repeat (4) tick();
        axis_rst = 1'b1;
        tick();
        axis_rst = 1'b0;
        exp_q.delete();
        ea_q.delete();
        @(negedge axis_clk);
        check1("abort_idle", ap_idle, 1'b1);
        check1("abort_ssrdy", ss_tready, 1'b0);
        check1("abort_smvld", sm_tvalid, 1'b0);
        quiet = 0;
        repeat (30) begin
            @(negedge axis_clk);
            if (sm_tvalid || ss_tready) quiet++;
        end
        check("abort_quiet", 64'(quiet), 64'(0));
        tick();
        run_job(5, -1, 1, 1'b0, 1'b0);

        // randomized jobs with random taps, gaps and output stalls
        for (int j = 0; j < 6; j++) begin
            for (int t = 0; t < T; t++) h[t] = DW'($urandom);
            rdy_pct = $urandom_range(30, 100);
            run_job($urandom_range(1, 25), -1, $urandom_range(0, 3), 1'b0, 1'b0);
        end
        rdy_pct = 100;

        repeat (5) tick();
        check("sb_empty", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
